// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and sizing helpers for the FIFO write-port arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, OWN)
//   - clog2       : ceiling log2 for elaboration-time sizing
//   - idx_width   : producer index width (never below 1 bit)
//   - cnt_width   : burst counter width, wide enough to hold MAX_BURST
package fifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

   localparam int DEF_N         = 4;
   localparam int DEF_W         = 8;
   localparam int DEF_MAX_BURST = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int idx_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   function automatic int cnt_width(input int max_burst);
      return clog2(max_burst) + 1;
   endfunction

   // Widths for the default configuration.
   localparam int DEF_IDX_W = idx_width(DEF_N);
   localparam int DEF_CNT_W = cnt_width(DEF_MAX_BURST);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Finds the first set request bit at or
//   above ptr, wrapping modulo N.
//   Ports:
//     req  in  N      request vector
//     ptr  in  IDX_W  search start index (0..N-1)
//     any  out 1      at least one request is set
//     idx  out IDX_W  chosen index (0 when any=0)
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      int j;
      any = 1'b0;
      idx = '0;
      j   = 0;
      for (int k = 0; k < N; k++) begin
         // Candidate position k steps after ptr, folded back into 0..N-1.
         j = int'(ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!any && req[j]) begin
            any = 1'b1;
            idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among N producers. A
//   producer is granted after a one-cycle arbitration in IDLE, may then write
//   up to MAX_BURST words, and releases early if it drops its request. FIFO
//   full stalls the owner without releasing the grant.
//   Ports:
//     clk        in  1      rising-edge clock
//     reset      in  1      asynchronous reset, active low
//     req        in  N      per-producer valid
//     data_in    in  N*W    producer data, slice i = data_in[i*W +: W]
//     fifo_full  in  1      FIFO full back-pressure
//     ack        out N      one-hot, producer word consumed this cycle
//     fifo_wr    out 1      FIFO write strobe
//     fifo_data  out W      FIFO write data (0 when not owning)
//     gnt_id     out IDXW   current / last owner index
//     busy       out 1      a producer currently owns the port
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int W         = DEF_W,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N-1:0]              req,
   input  logic [N*W-1:0]            data_in,
   input  logic                      fifo_full,
   output logic [N-1:0]              ack,
   output logic                      fifo_wr,
   output logic [W-1:0]              fifo_data,
   output logic [idx_width(N)-1:0]   gnt_id,
   output logic                      busy
);

   localparam int IDX_W = idx_width(N);
   localparam int CNT_W = cnt_width(MAX_BURST);

   arb_state_e       state_q;
   logic [IDX_W-1:0] gnt_q;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [CNT_W-1:0] burst_q;
   logic [CNT_W-1:0] burst_d;
   logic             last_beat;
   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic [W-1:0]     data_slice [N];

   rr_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_port
         assign data_slice[gi] = data_in[gi*W +: W];
         assign ack[gi]        = fifo_wr & (gnt_q == IDX_W'(gi));
      end
   endgenerate

   assign busy      = (state_q == OWN);
   // Write is combinational so a stall ends the very cycle full drops.
   assign fifo_wr   = busy & req[gnt_q] & ~fifo_full;
   assign fifo_data = busy ? data_slice[gnt_q] : '0;
   assign gnt_id    = gnt_q;

   // Pointer moves just past the releasing owner so it goes to the back.
   assign ptr_d     = (gnt_q == IDX_W'(N - 1)) ? '0 : gnt_q + IDX_W'(1);
   assign burst_d   = burst_q + CNT_W'(1);
   assign last_beat = (burst_q == CNT_W'(MAX_BURST - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         burst_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  gnt_q   <= pick_idx;
                  burst_q <= '0;
                  state_q <= OWN;
               end
            end
            OWN: begin
               if (fifo_wr) begin
                  if (last_beat) begin
                     state_q <= IDLE;
                     ptr_q   <= ptr_d;
                  end else begin
                     burst_q <= burst_d;
                  end
               end else if (!req[gnt_q]) begin
                  // Owner went quiet; a full-only stall keeps the grant.
                  state_q <= IDLE;
                  ptr_q   <= ptr_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench: a per-cycle vector table on a MAX_BURST=4 instance, a
//   mid-cycle asynchronous reset sequence, and a strict word-level rotation
//   sequence on a MAX_BURST=1 instance sharing the same inputs.
module tb_fifo_wr_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req;
   logic [31:0]  data_in;
   logic         fifo_full;

   logic [3:0]   a_ack;
   logic         a_wr;
   logic [7:0]   a_data;
   logic [1:0]   a_gnt;
   logic         a_busy;

   logic [3:0]   b_ack;
   logic         b_wr;
   logic [7:0]   b_data;
   logic [1:0]   b_gnt;
   logic         b_busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.N(N), .W(W), .MAX_BURST(4)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .data_in   (data_in),
      .fifo_full (fifo_full),
      .ack       (a_ack),
      .fifo_wr   (a_wr),
      .fifo_data (a_data),
      .gnt_id    (a_gnt),
      .busy      (a_busy)
   );

   fifo_wr_arbiter #(.N(N), .W(W), .MAX_BURST(1)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .data_in   (data_in),
      .fifo_full (fifo_full),
      .ack       (b_ack),
      .fifo_wr   (b_wr),
      .fifo_data (b_data),
      .gnt_id    (b_gnt),
      .busy      (b_busy)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [7:0] p0;
      logic [7:0] p1;
      logic [7:0] p2;
      logic [7:0] p3;
      logic       full;
      logic [3:0] ack;
      logic       wr;
      logic [7:0] dat;
      logic [1:0] gnt;
      logic       busy;
   } vec_t;

   localparam int NV = 32;
   vec_t vecs [NV];

   function automatic vec_t mk(input int rst, input int rq, input int p0, input int p1,
                               input int p2, input int p3, input int full, input int ak,
                               input int wr, input int dat, input int gnt, input int bsy);
      vec_t v;
      v.rst  = 1'(rst);
      v.req  = 4'(rq);
      v.p0   = 8'(p0);
      v.p1   = 8'(p1);
      v.p2   = 8'(p2);
      v.p3   = 8'(p3);
      v.full = 1'(full);
      v.ack  = 4'(ak);
      v.wr   = 1'(wr);
      v.dat  = 8'(dat);
      v.gnt  = 2'(gnt);
      v.busy = 1'(bsy);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int order [5];
      int vals [4];
      int last;
      int p;

      reset     = 1'b0;
      req       = '0;
      data_in   = '0;
      fifo_full = 1'b0;

      // rst req p0 p1 p2 p3 full | ack wr dat gnt busy
      vecs[0]  = mk(0, 4'b1111, 100, 11, 22, 33, 0,  4'b0000, 0,   0, 0, 0); // held in reset
      vecs[1]  = mk(1, 4'b1111, 100, 11, 22, 33, 0,  4'b0000, 0,   0, 0, 0); // IDLE arbitration
      vecs[2]  = mk(1, 4'b0001, 100, 11, 22, 33, 0,  4'b0001, 1, 100, 0, 1); // burst word 1
      vecs[3]  = mk(1, 4'b0001, 150, 11, 22, 33, 0,  4'b0001, 1, 150, 0, 1);
      vecs[4]  = mk(1, 4'b0001, 200, 11, 22, 33, 0,  4'b0001, 1, 200, 0, 1);
      vecs[5]  = mk(1, 4'b0001,  40, 11, 22, 33, 0,  4'b0001, 1,  40, 0, 1); // 4th word, release
      vecs[6]  = mk(1, 4'b0001,  70, 11, 22, 33, 0,  4'b0000, 0,   0, 0, 0); // bubble
      vecs[7]  = mk(1, 4'b0001,  70, 11, 22, 33, 0,  4'b0001, 1,  70, 0, 1); // regrant to 0
      vecs[8]  = mk(1, 4'b0000,  70, 11, 22, 33, 0,  4'b0000, 0,  70, 0, 1); // drop, release
      vecs[9]  = mk(1, 4'b0000,  70, 11, 22, 33, 0,  4'b0000, 0,   0, 0, 0);
      vecs[10] = mk(1, 4'b0100,  70, 11, 22, 33, 0,  4'b0000, 0,   0, 0, 0); // arbitrate to 2
      vecs[11] = mk(1, 4'b0100,  70, 11, 21, 33, 0,  4'b0100, 1,  21, 2, 1);
      vecs[12] = mk(1, 4'b0100,  70, 11, 22, 33, 1,  4'b0000, 0,  22, 2, 1); // full stall
      vecs[13] = mk(1, 4'b0100,  70, 11, 22, 33, 1,  4'b0000, 0,  22, 2, 1);
      vecs[14] = mk(1, 4'b0100,  70, 11, 22, 33, 1,  4'b0000, 0,  22, 2, 1);
      vecs[15] = mk(1, 4'b0100,  70, 11, 22, 33, 0,  4'b0100, 1,  22, 2, 1); // resume
      vecs[16] = mk(1, 4'b0100,  70, 11, 23, 33, 0,  4'b0100, 1,  23, 2, 1);
      vecs[17] = mk(1, 4'b0100,  70, 11, 24, 33, 0,  4'b0100, 1,  24, 2, 1); // 4th word, release
      vecs[18] = mk(1, 4'b0100,  70, 11, 25, 33, 0,  4'b0000, 0,   0, 2, 0); // bubble, gnt held
      vecs[19] = mk(1, 4'b0000,  70, 11, 25, 33, 0,  4'b0000, 0,  25, 2, 1); // drop, release
      vecs[20] = mk(1, 4'b0000,  70, 11, 25, 33, 0,  4'b0000, 0,   0, 2, 0);
      vecs[21] = mk(1, 4'b0010,  70, 11, 25, 33, 0,  4'b0000, 0,   0, 2, 0); // arbitrate to 1
      vecs[22] = mk(1, 4'b1010,  70, 11, 25, 33, 0,  4'b0010, 1,  11, 1, 1); // req3 waits
      vecs[23] = mk(1, 4'b1010,  70, 12, 25, 33, 0,  4'b0010, 1,  12, 1, 1);
      vecs[24] = mk(1, 4'b1000,  70, 12, 25, 33, 0,  4'b0000, 0,  12, 1, 1); // early drop, ptr=2
      vecs[25] = mk(1, 4'b1001,  70, 12, 25, 33, 0,  4'b0000, 0,   0, 1, 0); // ptr=2 picks 3 over 0
      vecs[26] = mk(1, 4'b1001,  70, 12, 25, 33, 0,  4'b1000, 1,  33, 3, 1);
      vecs[27] = mk(1, 4'b0001,  70, 12, 25, 33, 0,  4'b0000, 0,  33, 3, 1); // drop, ptr wraps to 0
      vecs[28] = mk(1, 4'b0001,  70, 12, 25, 33, 0,  4'b0000, 0,   0, 3, 0);
      vecs[29] = mk(1, 4'b0001,  70, 12, 25, 33, 0,  4'b0001, 1,  70, 0, 1);
      vecs[30] = mk(1, 4'b0000,  70, 12, 25, 33, 0,  4'b0000, 0,  70, 0, 1);
      vecs[31] = mk(1, 4'b0000,  70, 12, 25, 33, 0,  4'b0000, 0,   0, 0, 0);

      @(posedge clk);
      #1;
      for (int i = 0; i < NV; i++) begin
         reset     = vecs[i].rst;
         req       = vecs[i].req;
         data_in   = {vecs[i].p3, vecs[i].p2, vecs[i].p1, vecs[i].p0};
         fifo_full = vecs[i].full;
         @(negedge clk);
         chk($sformatf("v%0d_ack", i),  32'(a_ack),  32'(vecs[i].ack));
         chk($sformatf("v%0d_wr", i),   32'(a_wr),   32'(vecs[i].wr));
         chk($sformatf("v%0d_data", i), 32'(a_data), 32'(vecs[i].dat));
         chk($sformatf("v%0d_gnt", i),  32'(a_gnt),  32'(vecs[i].gnt));
         chk($sformatf("v%0d_busy", i), 32'(a_busy), 32'(vecs[i].busy));
         $display("vec %0d: req=%b full=%b ack=%b wr=%b data=%0d gnt=%0d busy=%b",
                  i, req, fifo_full, a_ack, a_wr, a_data, a_gnt, a_busy);
         @(posedge clk);
         #1;
      end

      // Asynchronous reset in the middle of a write cycle (ptr is 1 here).
      req     = 4'b0010;
      data_in = {8'd33, 8'd22, 8'd11, 8'd100};
      @(negedge clk);
      chk("async_idle_busy", 32'(a_busy), 32'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("async_pre_wr",   32'(a_wr),   32'(1));
      chk("async_pre_gnt",  32'(a_gnt),  32'(1));
      chk("async_pre_ack",  32'(a_ack),  32'(4'b0010));
      chk("async_pre_data", 32'(a_data), 32'(11));
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_wr",   32'(a_wr),   32'(0));
      chk("async_rst_ack",  32'(a_ack),  32'(0));
      chk("async_rst_busy", 32'(a_busy), 32'(0));
      chk("async_rst_gnt",  32'(a_gnt),  32'(0));
      chk("async_rst_data", 32'(a_data), 32'(0));
      $display("async reset: wr=%b ack=%b busy=%b gnt=%0d", a_wr, a_ack, a_busy, a_gnt);
      @(posedge clk);
      #1;
      reset = 1'b1;
      req   = 4'b1111;
      @(negedge clk);
      chk("restart_idle_busy", 32'(a_busy), 32'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("restart_gnt",  32'(a_gnt),  32'(0));
      chk("restart_wr",   32'(a_wr),   32'(1));
      chk("restart_ack",  32'(a_ack),  32'(4'b0001));
      chk("restart_data", 32'(a_data), 32'(100));
      $display("restart: gnt=%0d wr=%b data=%0d", a_gnt, a_wr, a_data);

      // Strict word-level round robin on the MAX_BURST=1 instance.
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset   = 1'b1;
      req     = 4'b1111;
      data_in = {8'd33, 8'd22, 8'd11, 8'd100};
      order   = '{0, 1, 2, 3, 0};
      vals    = '{100, 11, 22, 33};
      last    = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k % 2 == 1) begin
            p = order[(k - 1) / 2];
            chk($sformatf("rot%0d_busy", k), 32'(b_busy), 32'(1));
            chk($sformatf("rot%0d_wr", k),   32'(b_wr),   32'(1));
            chk($sformatf("rot%0d_ack", k),  32'(b_ack),  32'(1) << p);
            chk($sformatf("rot%0d_data", k), 32'(b_data), 32'(vals[p]));
            chk($sformatf("rot%0d_gnt", k),  32'(b_gnt),  32'(p));
            last = p;
         end else begin
            chk($sformatf("rot%0d_busy", k), 32'(b_busy), 32'(0));
            chk($sformatf("rot%0d_wr", k),   32'(b_wr),   32'(0));
            chk($sformatf("rot%0d_ack", k),  32'(b_ack),  32'(0));
            chk($sformatf("rot%0d_gnt", k),  32'(b_gnt),  32'(last));
         end
         $display("rot %0d: wr=%b ack=%b data=%0d gnt=%0d busy=%b",
                  k, b_wr, b_ack, b_data, b_gnt, b_busy);
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one FIFO write port (wr, data_in, full) among N producers.
- Grants one producer at a time, lets it burst up to MAX_BURST words, then rotates.
- Honours FIFO full back-pressure.
- Sits between producer blocks and the FIFO instance; the FIFO read side is untouched.

Parameters:
N, 4, number of requesting producers (2..8)
W, 8, data width; matches FIFO data_in width
MAX_BURST, 4, max words accepted per grant before forced rotation (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  N  req[i]=1: producer i has a valid word on its data slice
data_in  input  N*W  flattened producer data; slice i = data_in[i*W +: W]
fifo_full  input  1  FIFO full flag
ack  output  N  one-hot; ack[i]=1 means producer i's word is written this cycle
fifo_wr  output  1  FIFO write strobe
fifo_data  output  W  FIFO write data
gnt_id  output  clog2(N)  current/last owner index
busy  output  1  1 while in OWN state

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; gnt_id=0, rr pointer=0, burst_cnt=0, busy=0.
  - ack, fifo_wr and fifo_data all 0.
  - Reset mid-burst aborts immediately; no write occurs while reset=0.
- States: IDLE, OWN.
- IDLE:
  - If req!=0, pick the first set req index searching upward from ptr, wrapping modulo N.
  - Register it into gnt_id, clear burst_cnt, go to OWN.
  - One-cycle arbitration latency; no write in IDLE.
- OWN:
  - fifo_wr = req[gnt_id] & ~fifo_full (combinational).
  - fifo_data = slice gnt_id of data_in (combinational mux, valid whenever busy).
  - ack[gnt_id] = fifo_wr; all other ack bits 0.
  - Each accepted write increments burst_cnt.
- Release OWN -> IDLE, with ptr <= (gnt_id+1) mod N, when either:
  - (a) req[gnt_id]=0 in a cycle, no write that cycle; or
  - (b) an accepted write with burst_cnt==MAX_BURST-1; that write completes, then release.
- Back-to-back grants always have exactly one IDLE bubble cycle.
- fifo_full=1 in OWN:
  - fifo_wr=0, ack=0, burst_cnt holds, grant held indefinitely (no timeout).
  - Writing resumes the first cycle full=0.
- Producer holds data stable until ack; req may drop only after ack or before grant.
- Requests arriving while another producer owns the grant wait; they are not visible until the next IDLE.
- MAX_BURST=1: release after every accepted word, giving strict word-level round robin.
- Fairness: with all req held, grant order is 0,1,..,N-1,0...
  - Worst-case wait = (N-1)*(MAX_BURST+1) cycles plus full stalls.
- gnt_id holds its last value in IDLE until the next grant.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, OWN};
  - function clog2;
  - localparams for index width and burst counter width (clog2(MAX_BURST)+1).
- Sub-module rr_pick (combinational): inputs req[N] and ptr; outputs any and idx (first set bit at or after ptr, wrapping).
- Top holds the FSM, ptr, burst_cnt and the output mux.

Test Plan:
- Reset: hold reset=0 with req=4'b1111 -> all outputs 0; release reset -> gnt_id=0 one cycle later, first fifo_wr the cycle after with fifo_data=producer0 value (e.g. 100).
- Burst limit: req=4'b0001, words 100,150,200,40,70 -> four acks (100,150,200,40), one IDLE bubble, regrant to 0, then 70 written.
- Rotation: req=4'b1111 continuously, MAX_BURST=1 -> write sequence from producers 0,1,2,3,0 with one-cycle gap between words; ack one-hot each write.
- Back-pressure: producer 2 owns, assert fifo_full for 3 cycles mid-burst -> fifo_wr=0 and ack=0 for 3 cycles, gnt_id stays 2, burst resumes with burst_cnt unchanged.
- Early drop: producer 1 sends 2 words then drops req, req[3]=1 waiting -> release after idle cycle, ptr=2, next grant to 3.
- Async reset mid-burst: assert reset=0 between clock edges while fifo_wr=1 -> fifo_wr/ack fall immediately; after release, arbitration restarts from producer 0.
